// File: rtl/image_median_filter.sv
// image_median_filter
// Streaming 3x3 median stage for a raster grey-pixel stream. One filtered pixel is
// produced per accepted input pixel, in raster order, replicated on R/G/B. Border
// pixels pass through unchanged; interior pixels take the median of their 3x3
// neighbourhood. One frame per reset; FRAME_DONE flags completion.
//
// Ports
//   HCLK        clock, rising edge
//   HRESET      asynchronous active-high reset
//   HSYNC_IN    DATA_IN valid (pixel accepted) this cycle
//   DATA_IN     8-bit grey input pixel
//   HSYNC_OUT   DATA_R/G/B valid this cycle (1-cycle pulse per pixel)
//   DATA_R/G/B  filtered pixel (all three identical), held between pulses
//   FRAME_DONE  high from the cycle after the last output pulse until reset
//
// FSM
//   state   | meaning
//   S_IDLE  | waiting for the first pixel of the frame
//   S_FILL  | line buffers priming, no centre issued yet
//   S_RUN   | every accepted pixel issues one centre
//   S_FLUSH | input ignored, issuing the trailing WIDTH+1 centres back-to-back
//   S_DONE  | frame complete, input ignored until reset
module image_median_filter #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSYNC_IN,
  input  logic [7:0] DATA_IN,
  output logic       HSYNC_OUT,
  output logic [7:0] DATA_R,
  output logic [7:0] DATA_G,
  output logic [7:0] DATA_B,
  output logic       FRAME_DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int FW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;
  logic   accept, issue, flush_step, shift;

  // position of the next pixel to be accepted
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  // position of the next centre to be issued
  logic [CW-1:0] c_col;
  logic [RW-1:0] c_row;
  // counts down the trailing centres still to issue in S_FLUSH
  logic [FW-1:0] flush_cnt;

  logic [7:0] lb0 [WIDTH];   // row above the incoming pixel
  logic [7:0] lb1 [WIDTH];   // two rows above the incoming pixel
  logic [7:0] win [3][3];    // [row][col], col 2 newest
  logic [7:0] nwin [3][3];   // window after this cycle's shift
  logic [23:0] col_srt [3];  // each window column sorted {hi, mid, lo}

  logic [7:0] s1_lo [3], s1_mid [3], s1_hi [3];
  logic [7:0] s1_ctr;
  logic       s1_valid, s1_border, s1_last;
  logic [7:0] s2_a, s2_b, s2_c, s2_ctr;
  logic       s2_valid, s2_border, s2_last;
  logic       out_last;

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  function automatic logic [23:0] sort3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    logic [7:0] lo, hi;
    lo = min2(a, b);
    hi = max2(a, b);
    if (c < lo)      return {hi, lo, c};
    else if (c > hi) return {c, hi, lo};
    else             return {hi, c, lo};
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (HSYNC_IN) state_nxt = S_FILL;
      S_FILL:  if (HSYNC_IN && in_row == RW'(1) && in_col == CW'(1)) state_nxt = S_RUN;
      S_RUN:   if (HSYNC_IN && in_row == ROW_LAST && in_col == COL_LAST) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept     = 1'b0;
    issue      = 1'b0;
    flush_step = 1'b0;
    case (state)
      S_IDLE: accept = HSYNC_IN;
      S_FILL: begin
        accept = HSYNC_IN;
        issue  = HSYNC_IN && in_row == RW'(1) && in_col == CW'(1);
      end
      S_RUN: begin
        accept = HSYNC_IN;
        issue  = HSYNC_IN;
      end
      S_FLUSH: begin
        issue      = 1'b1;
        flush_step = 1'b1;
      end
      default: ;
    endcase
  end

  assign shift = accept | flush_step;

  // ---------------- counters ----------------
  // In S_FLUSH the column pointer keeps walking so the line buffers still
  // deliver the last row's pixels into the window; the row never wraps.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      in_col    <= '0;
      in_row    <= '0;
      c_col     <= '0;
      c_row     <= '0;
      flush_cnt <= '0;
    end else begin
      if (shift) begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          if (accept && in_row != ROW_LAST) in_row <= in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
      end
      if (issue) begin
        if (c_col == COL_LAST) begin
          c_col <= '0;
          if (c_row != ROW_LAST) c_row <= c_row + RW'(1);
        end else begin
          c_col <= c_col + CW'(1);
        end
      end
      if (state == S_RUN && state_nxt == S_FLUSH) flush_cnt <= FLUSH_LOAD;
      else if (flush_step && flush_cnt != '0)     flush_cnt <= flush_cnt - FW'(1);
    end
  end

  // ---------------- line buffers (not reset) ----------------
  always_ff @(posedge HCLK) begin
    if (accept) begin
      lb0[in_col] <= DATA_IN;
      lb1[in_col] <= lb0[in_col];
    end
  end

  // ---------------- window ----------------
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nwin[r][0] = win[r][1];
      nwin[r][1] = win[r][2];
    end
    nwin[0][2] = lb1[in_col];
    nwin[1][2] = lb0[in_col];
    nwin[2][2] = accept ? DATA_IN : 8'd0;   // flushed centres are all border
    for (int c = 0; c < 3; c++) col_srt[c] = sort3(nwin[0][c], nwin[1][c], nwin[2][c]);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else if (shift) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= nwin[r][c];
    end
  end

  // ---------------- median pipeline ----------------
  // Stage 1: sort each column. Stage 2: max of lows, median of mids, min of highs.
  // Stage 3: median of those three, or the centre itself on the border.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int c = 0; c < 3; c++) begin
        s1_lo[c]  <= '0;
        s1_mid[c] <= '0;
        s1_hi[c]  <= '0;
      end
      s1_ctr    <= '0;
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_last   <= 1'b0;
      s2_a      <= '0;
      s2_b      <= '0;
      s2_c      <= '0;
      s2_ctr    <= '0;
      s2_valid  <= 1'b0;
      s2_border <= 1'b0;
      s2_last   <= 1'b0;
      HSYNC_OUT <= 1'b0;
      DATA_R    <= '0;
      out_last  <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        for (int c = 0; c < 3; c++) begin
          s1_hi[c]  <= col_srt[c][23:16];
          s1_mid[c] <= col_srt[c][15:8];
          s1_lo[c]  <= col_srt[c][7:0];
        end
        s1_ctr    <= nwin[1][1];
        s1_border <= (c_row == '0) || (c_row == ROW_LAST) ||
                     (c_col == '0) || (c_col == COL_LAST);
        s1_last   <= (c_row == ROW_LAST) && (c_col == COL_LAST);
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a      <= max2(max2(s1_lo[0], s1_lo[1]), s1_lo[2]);
        s2_b      <= med3(s1_mid[0], s1_mid[1], s1_mid[2]);
        s2_c      <= min2(min2(s1_hi[0], s1_hi[1]), s1_hi[2]);
        s2_ctr    <= s1_ctr;
        s2_border <= s1_border;
        s2_last   <= s1_last;
      end

      HSYNC_OUT <= s2_valid;
      out_last  <= s2_valid && s2_last;
      if (s2_valid) DATA_R <= s2_border ? s2_ctr : med3(s2_a, s2_b, s2_c);

      if (out_last) FRAME_DONE <= 1'b1;
    end
  end

  assign DATA_G = DATA_R;
  assign DATA_B = DATA_R;

endmodule

// File: tb/tb_image_median_filter.sv
module tb_image_median_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, hs_in, hs_out, fd;
  logic [1:0][7:0] din, dr, dg, db;

  // index 0: 4x4 frame, index 1: 5x5 frame
  image_median_filter #(.WIDTH(4), .HEIGHT(4)) u4 (
    .HCLK(clk), .HRESET(rst[0]), .HSYNC_IN(hs_in[0]), .DATA_IN(din[0]),
    .HSYNC_OUT(hs_out[0]), .DATA_R(dr[0]), .DATA_G(dg[0]), .DATA_B(db[0]),
    .FRAME_DONE(fd[0]));

  image_median_filter #(.WIDTH(5), .HEIGHT(5)) u5 (
    .HCLK(clk), .HRESET(rst[1]), .HSYNC_IN(hs_in[1]), .DATA_IN(din[1]),
    .HSYNC_OUT(hs_out[1]), .DATA_R(dr[1]), .DATA_G(dg[1]), .DATA_B(db[1]),
    .FRAME_DONE(fd[1]));

  typedef struct {
    logic [7:0] r, g, b;
    int         c;
  } obs_t;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  obs_t       obs0[$], obs1[$];
  int         fd_cyc [2];
  logic [7:0] pix[$];
  int         in_c[$];
  int         start_c;

  vec_t tbl_flat [16];
  vec_t tbl_ramp [16];
  vec_t tbl_imp  [25];

  always @(negedge clk) begin
    obs_t o;
    if (hs_out[0]) begin
      o.r = dr[0]; o.g = dg[0]; o.b = db[0]; o.c = cyc;
      obs0.push_back(o);
    end
    if (hs_out[1]) begin
      o.r = dr[1]; o.g = dg[1]; o.b = db[1]; o.c = cyc;
      obs1.push_back(o);
    end
    if (fd[0] && fd_cyc[0] < 0) fd_cyc[0] = cyc;
    if (fd[1] && fd_cyc[1] < 0) fd_cyc[1] = cyc;
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // reference: border pixels pass, interior = 5th smallest of the 3x3 neighbourhood
  function automatic int ref_med(input int w, input int h, input int k);
    int r, c, v[9], t, i;
    r = k / w;
    c = k % w;
    if (r == 0 || r == h - 1 || c == 0 || c == w - 1) return int'(pix[k]);
    i = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        v[i] = int'(pix[(r + dy) * w + c + dx]);
        i++;
      end
    for (int a = 0; a < 9; a++)
      for (int b = 0; b < 8 - a; b++)
        if (v[b] > v[b + 1]) begin
          t = v[b]; v[b] = v[b + 1]; v[b + 1] = t;
        end
    return v[4];
  endfunction

  // centre k is issued with input pixel k+w+1, or in the flush burst after the last input
  function automatic int exp_out_cyc(input int w, input int h, input int k);
    int total;
    total = w * h;
    if (k + w + 1 <= total - 1) return in_c[k + w + 1] + 3;
    return in_c[total - 1] + (k - (total - w - 2)) + 3;
  endfunction

  task automatic do_reset(input int sel);
    rst[sel]   = 1'b1;
    hs_in[sel] = 1'b0;
    din[sel]   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("reset_hsync_out[%0d]", sel), int'(hs_out[sel]), 0);
    chk($sformatf("reset_data_r[%0d]", sel), int'(dr[sel]), 0);
    chk($sformatf("reset_frame_done[%0d]", sel), int'(fd[sel]), 0);
    rst[sel] = 1'b0;
    if (sel == 0) obs0.delete();
    else          obs1.delete();
    fd_cyc[sel] = -1;
  endtask

  // gap_mode: 0 contiguous, 1 every other cycle, 2 random 0..3 idle cycles
  task automatic run_frame(input int sel, input int w, input int h, input int gap_mode);
    int gap;
    in_c.delete();
    @(posedge clk);
    #1;
    start_c = cyc;
    for (int n = 0; n < w * h; n++) begin
      hs_in[sel] = 1'b1;
      din[sel]   = pix[n];
      in_c.push_back(cyc - start_c);
      @(posedge clk);
      #1;
      hs_in[sel] = 1'b0;
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      if (n != w * h - 1)
        repeat (gap) begin
          din[sel] = 8'($urandom);
          @(posedge clk);
          #1;
        end
    end
    hs_in[sel] = 1'b0;
    for (int i = 0; i < 300 && !fd[sel]; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int sel, input int w, input int h, input string tag);
    obs_t o[$];
    int   total, n, ev;
    o = (sel == 1) ? obs1 : obs0;
    total = w * h;
    chk({tag, "_pulse_count"}, o.size(), total);
    chk({tag, "_frame_done_seen"}, int'(fd_cyc[sel] >= 0), 1);
    n = (o.size() < total) ? o.size() : total;
    for (int k = 0; k < n; k++) begin
      ev = ref_med(w, h, k);
      chk($sformatf("%s_r[%0d]", tag, k), int'(o[k].r), ev);
      chk($sformatf("%s_g[%0d]", tag, k), int'(o[k].g), ev);
      chk($sformatf("%s_b[%0d]", tag, k), int'(o[k].b), ev);
      chk($sformatf("%s_cycle[%0d]", tag, k), o[k].c - start_c, exp_out_cyc(w, h, k));
    end
    chk({tag, "_frame_done_cycle"}, fd_cyc[sel] - start_c, exp_out_cyc(w, h, total - 1) + 1);
  endtask

  task automatic run_table(input int sel, input int w, input int h, input vec_t tv[$],
                           input int gap_mode, input string tag);
    obs_t o[$];
    pix.delete();
    foreach (tv[i]) pix.push_back(tv[i].din);
    do_reset(sel);
    run_frame(sel, w, h, gap_mode);
    check_frame(sel, w, h, tag);
    o = (sel == 1) ? obs1 : obs0;
    for (int k = 0; k < tv.size() && k < o.size(); k++)
      chk($sformatf("%s_table[%0d]", tag, k), int'(o[k].r), int'(tv[k].exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tq[$];
    int   s;

    // flat 0x55 frame; impulse-only 5x5 frame; ramp whose medians equal the centre
    for (int n = 0; n < 16; n++) begin
      tbl_flat[n].din = 8'h55;
      tbl_flat[n].exp = 8'h55;
      tbl_ramp[n].din = 8'(n * 16);
      tbl_ramp[n].exp = 8'(n * 16);
    end
    for (int n = 0; n < 25; n++) begin
      tbl_imp[n].din = 8'h10;
      tbl_imp[n].exp = 8'h10;
    end
    tbl_imp[12].din = 8'hFF;
    tbl_imp[6].din  = 8'h00;

    rst   = 2'b11;
    hs_in = 2'b00;
    din   = '0;
    fd_cyc[0] = -1;
    fd_cyc[1] = -1;
    repeat (2) @(posedge clk);

    // flat 4x4 frame: values and exact timing
    tq.delete();
    foreach (tbl_flat[i]) tq.push_back(tbl_flat[i]);
    run_table(0, 4, 4, tq, 0, "flat");
    if (obs0.size() == 16) begin
      chk("flat_first_out_cycle", obs0[0].c - start_c, 8);
      chk("flat_last_out_cycle", obs0[15].c - start_c, 23);
    end else chk("flat_out_count_for_timing", obs0.size(), 16);
    chk("flat_frame_done_at_24", fd_cyc[0] - start_c, 24);

    // input after the frame is dropped
    hs_in[0] = 1'b1;
    din[0]   = 8'hAA;
    repeat (4) @(posedge clk);
    #1;
    hs_in[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("excess_input_no_pulses", obs0.size(), 16);
    chk("excess_input_done_held", int'(fd[0]), 1);

    // impulses removed on 5x5
    tq.delete();
    foreach (tbl_imp[i]) tq.push_back(tbl_imp[i]);
    run_table(1, 5, 5, tq, 0, "impulse");

    // 4x4 ramp: borders pass, interior equals the local median
    tq.delete();
    foreach (tbl_ramp[i]) tq.push_back(tbl_ramp[i]);
    run_table(0, 4, 4, tq, 0, "ramp");
    if (obs0.size() == 16) begin
      chk("ramp_interior_1_1", int'(obs0[5].r), 8'h50);
      chk("ramp_interior_2_2", int'(obs0[10].r), 8'hA0);
    end

    // flat frame with input every other cycle: flush outputs back-to-back
    tq.delete();
    foreach (tbl_flat[i]) tq.push_back(tbl_flat[i]);
    run_table(0, 4, 4, tq, 1, "sparse");
    if (obs0.size() == 16)
      for (int k = 11; k < 16; k++)
        chk($sformatf("sparse_consecutive[%0d]", k), obs0[k].c - obs0[k - 1].c, 1);

    // reset in the middle of a frame
    do_reset(0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 8; n++) begin
      hs_in[0] = 1'b1;
      din[0]   = 8'h55;
      @(posedge clk);
      #1;
    end
    hs_in[0] = 1'b0;
    chk("midreset_pre_pulse", int'(hs_out[0]), 1);
    chk("midreset_pre_data", int'(dr[0]), 8'h55);
    #2;
    rst[0] = 1'b1;
    #1;
    chk("midreset_hsync_out", int'(hs_out[0]), 0);
    chk("midreset_data_r", int'(dr[0]), 0);
    chk("midreset_data_g", int'(dg[0]), 0);
    chk("midreset_data_b", int'(db[0]), 0);
    chk("midreset_frame_done", int'(fd[0]), 0);
    tq.delete();
    foreach (tbl_flat[i]) tq.push_back(tbl_flat[i]);
    run_table(0, 4, 4, tq, 0, "after_reset");

    // randomized frames with salt/pepper noise and random input gaps
    for (int f = 0; f < 4; f++) begin
      s = (f == 3) ? 0 : 1;
      pix.delete();
      for (int n = 0; n < ((s == 1) ? 25 : 16); n++) begin
        case ($urandom_range(0, 9))
          0:       pix.push_back(8'h00);
          1:       pix.push_back(8'hFF);
          2, 3:    pix.push_back(8'($urandom));
          default: pix.push_back(8'($urandom_range(8'h40, 8'h60)));
        endcase
      end
      do_reset(s);
      run_frame(s, (s == 1) ? 5 : 4, (s == 1) ? 5 : 4, 2);
      check_frame(s, (s == 1) ? 5 : 4, (s == 1) ? 5 : 4, $sformatf("random%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
